// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode and direction encodings for the universal shift register
package univ_shift_reg_pkg;

  // Operation select driven on the mode port
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Direction of the most recent shift; selects which end drives so
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_frame_counter.sv
// rtl/shift_frame_counter.sv - counts shifted bits per frame and pulses frame_done on wrap
module shift_frame_counter
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic shift_evt,
  input  logic restart,
  output logic frame_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: restart wins, the WIDTH-th shift wraps to 0 and raises done for one cycle
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (shift_evt) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers; clear discards any partial frame immediately
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with hold/shl/shr/load and frame tracking
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  dir_e             dir_q, dir_d;
  logic             shift_evt;
  logic             restart;

  // Mode mux; en low degrades every mode to HOLD
  always_comb begin
    q_d       = q_q;
    dir_d     = dir_q;
    shift_evt = 1'b0;
    restart   = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHL: begin
          q_d       = {q_q[WIDTH-2:0], si_r};
          dir_d     = DIR_LEFT;
          shift_evt = 1'b1;
        end
        MODE_SHR: begin
          q_d       = {si_l, q_q[WIDTH-1:1]};
          dir_d     = DIR_RIGHT;
          shift_evt = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = pin;
          restart = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // Data and direction registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_q   <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
    end
  end

  shift_frame_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_frame_counter (
    .clk       (clk),
    .clear     (clear),
    .shift_evt (shift_evt),
    .restart   (restart),
    .frame_done(frame_done)
  );

  assign pout = q_q;
  // so comes only from registers: the end that the last shift moved toward
  assign so   = (dir_q == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule
